// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: standard I2S transmitter with a one-frame-ahead holding register, gated by PLL lock.
module audio_i2s_tx #(
    parameter int AUDIO_W   = 16,
    parameter int SCLK_HALF = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pll_locked,
    input  logic [AUDIO_W-1:0] left_in,
    input  logic [AUDIO_W-1:0] right_in,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               i2s_sclk,
    output logic               i2s_lrck,
    output logic               i2s_sdata,
    output logic               frame_start,
    output logic               underrun
);
    localparam int DW = SCLK_HALF > 1 ? $clog2(SCLK_HALF) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state, state_n;
    logic                 lock_meta;
    logic [DW-1:0]        div_cnt, div_n;
    logic [5:0]           cnt, cnt_n, slot;
    logic                 sclk_n, lrck_n, sdata_n, frame_start_n, underrun_n;
    logic [2*AUDIO_W-1:0] hold, hold_n, shadow, shadow_n;
    logic                 hold_full, hold_full_n;
    logic                 wrap, fall, load;
    logic [AUDIO_W-1:0]   word;
    logic [31:0]          word32;

    assign in_ready = !hold_full;

    // cnt runs two ahead of the slot index, so its cleared value 0 is slot 62 at RUN entry
    always_comb begin
        state_n       = lock_meta ? RUN : IDLE;
        wrap          = div_cnt == DW'(SCLK_HALF - 1);
        fall          = state == RUN && wrap && i2s_sclk;
        slot          = cnt + 6'd63;
        load          = fall && slot == 6'd63;
        word          = slot[5] ? shadow[AUDIO_W-1:0] : shadow[2*AUDIO_W-1:AUDIO_W];
        word32        = 32'(word) << (32 - AUDIO_W);
        div_n         = (state == IDLE || wrap) ? '0 : div_cnt + DW'(1);
        cnt_n         = state == IDLE ? '0 : cnt + 6'(fall);
        sclk_n        = state == RUN && (i2s_sclk ^ wrap);
        lrck_n        = state == RUN && (fall ? (slot >= 6'd31 && slot != 6'd63) : i2s_lrck);
        sdata_n       = state == RUN && (fall ? word32[~slot[4:0]] : i2s_sdata);
        frame_start_n = load;
        underrun_n    = load && !hold_full && !in_valid;
        shadow_n      = state == IDLE ? '0 :
                        load ? (hold_full ? hold : in_valid ? {left_in, right_in} : '0) : shadow;
        hold_n        = hold;
        hold_full_n   = hold_full;
        if (load && hold_full) begin
            hold_full_n = 1'b0;
        end else if (in_valid && !hold_full && !load) begin
            hold_n      = {left_in, right_in};
            hold_full_n = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta   <= 1'b0;
            state       <= IDLE;
            div_cnt     <= '0;
            cnt         <= '0;
            i2s_sclk    <= 1'b0;
            i2s_lrck    <= 1'b0;
            i2s_sdata   <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            hold        <= '0;
            hold_full   <= 1'b0;
            shadow      <= '0;
        end else begin
            lock_meta   <= pll_locked;
            state       <= state_n;
            div_cnt     <= div_n;
            cnt         <= cnt_n;
            i2s_sclk    <= sclk_n;
            i2s_lrck    <= lrck_n;
            i2s_sdata   <= sdata_n;
            frame_start <= frame_start_n;
            underrun    <= underrun_n;
            hold        <= hold_n;
            hold_full   <= hold_full_n;
            shadow      <= shadow_n;
        end
    end
endmodule

// File: doc/audio_i2s_tx.md
Name: audio_i2s_tx

Overview:
I2S serial transmitter clocked by the 24.576 MHz audio PLL output. It takes parallel stereo samples through a valid/ready handshake and buffers one frame ahead. It generates SCLK, LRCK and SDATA, giving 48 kHz, 64-bit-per-frame standard I2S at default settings. Output is held idle until the PLL reports lock.

Parameters:
AUDIO_W, 16, sample width per channel; legal range 8..32; MSB-aligned within a 32-bit slot.
SCLK_HALF, 4, clk cycles per SCLK half-period; minimum 1; frame period = 128*SCLK_HALF clk cycles.

Ports:
clk  input  1  audio clock; all logic on rising edge.
rst_n  input  1  asynchronous active-low reset.
pll_locked  input  1  PLL lock; asynchronous to logic, 2-flop synchronised internally.
left_in  input  AUDIO_W  left sample, two's complement.
right_in  input  AUDIO_W  right sample.
in_valid  input  1  sample pair valid.
in_ready  output  1  holding register empty; transfer occurs when in_valid & in_ready.
i2s_sclk  output  1  bit clock.
i2s_lrck  output  1  word select; 0 = left, 1 = right.
i2s_sdata  output  1  serial data, MSB first.
frame_start  output  1  one-clk pulse on each shadow load.
underrun  output  1  one-clk pulse when a frame loads with no sample available.

Behaviour:
- Reset values: i2s_sclk, i2s_lrck, i2s_sdata, frame_start and underrun are 0; in_ready is 1; all counters are 0; state is IDLE.
- Storage: holding register (hold, hold_full) plus a shadow register being serialised. in_ready = !hold_full in every state. Accepting writes hold and sets hold_full.
- States:
  - IDLE: outputs 0, counters cleared.
  - IDLE -> RUN when synchronised lock = 1. On entry: div_cnt = 0, sclk = 0, slot s = 62.
  - RUN -> IDLE on the same clk that synchronised lock = 0. Outputs return to 0, shadow is cleared, hold is retained.
- Timing in RUN:
  - div_cnt counts 0..SCLK_HALF-1; i2s_sclk toggles at each wrap.
  - Falling event = the wrap where sclk goes 1 -> 0. Only on a falling event: s <= (s+1) mod 64, and i2s_lrck / i2s_sdata update (registered).
  - The first falling event is 2*SCLK_HALF clk after RUN entry.
- Slot mapping, applied after the s update:
  - i2s_lrck = 1 for s in 31..62, else 0. LRCK therefore leads the MSB by one bit.
  - i2s_sdata = shadow_left[AUDIO_W-1-s] for s in 0..AUDIO_W-1.
  - i2s_sdata = shadow_right[AUDIO_W-1-(s-32)] for s in 32..31+AUDIO_W.
  - i2s_sdata = 0 in all other slots.
- Load event: the falling event where s becomes 63. frame_start pulses.
  - If hold_full: shadow <= hold, hold_full <= 0. A simultaneous in_valid is not accepted, because in_ready was 0.
  - Else if in_valid: bypass; shadow <= inputs, the transfer counts as accepted, no underrun, hold stays empty.
  - Else: shadow <= 0 and underrun pulses.
- Data changes only on SCLK falling events, so the receiver samples on rising edges.
- Latency from an accepted sample to its left MSB on SDATA: at most one frame plus 2*SCLK_HALF clk.
- rst_n asserted mid-frame: all state returns to reset values immediately. Counters restart from IDLE after release.

Test Plan:
1. pll_locked=0 for 100 clk -> all I2S outputs 0, in_ready=1. Raise pll_locked -> RUN after 2 clk; sclk period 8 clk; first frame_start 8 clk after RUN entry; frame_start period 512 clk.
2. Push left=16'h8001, right=16'h7FFE before the first load -> capture on SCLK rising edges. LRCK falls one bit before left MSB. Left bits read 1,0..0,1; right bits read 0,1..1,0; slots 16..31 and 48..63 read 0.
3. No in_valid for 3 frames -> underrun pulses once per frame (3 total), SDATA constant 0, LRCK still toggling.
4. Hold in_valid=1 continuously with incrementing data -> exactly one accept per frame; in_ready=0 between accept and the next load; serialised values are consecutive with none skipped.
5. hold empty; assert in_valid only on the load-event clk with 16'h1234/16'h5678 -> no underrun; that frame serialises 1234/5678; in_ready stays 1.
6. Drop pll_locked at s=40, then reassert; separately pulse rst_n low mid-frame -> outputs 0 within 3 clk (lock drop) and immediately (reset). Held sample is retained after the lock drop and cleared after reset. Restart timing matches scenario 1.
